// File: rtl/ysyx_22041412_div_ctrl.sv
// RV64M divide/remainder control: operand extension, special-case shortcut,
// sign fixup around an unsigned iterative divider, flush draining and hang timeout.
module ysyx_22041412_div_ctrl #(
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        ex_ready,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic        err,
    output logic [63:0] div_dividend,
    output logic [63:0] div_divisor,
    output logic        div_valid,
    output logic        div_divw,
    output logic        div_signed,
    output logic        div_mode,
    input  logic        div_out_valid,
    input  logic [63:0] div_result
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    function automatic logic [63:0] ext_op(input logic [63:0] v, input logic word, input logic sgn);
        logic [63:0] r;
        if (word) begin
            r = sgn ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [63:0] neg_if(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    function automatic logic [63:0] word_fix(input logic [63:0] v, input logic word);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    state_e      state_q;
    logic [2:0]  op_q;
    logic        a_neg_q, b_neg_q;
    logic [15:0] cnt_q;
    logic        ex_ready_q, wb_valid_q, err_q, div_valid_q, div_mode_q;
    logic [63:0] wb_data_q, div_dividend_q, div_divisor_q;

    logic        sgn_s, word_s, zero_s, ovf_s, fix_neg_s;
    logic [63:0] a_ext_s, b_ext_s, min_s, spec_res_s, fix_res_s;

    // Acceptance-time decode of the raw operands and the divider result fixup
    always_comb begin
        sgn_s      = ~ex_op[1];
        word_s     = ex_op[2];
        a_ext_s    = ext_op(src1, word_s, sgn_s);
        b_ext_s    = ext_op(src2, word_s, sgn_s);
        min_s      = word_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        zero_s     = (b_ext_s == 64'd0);
        ovf_s      = sgn_s && (a_ext_s == min_s) && (b_ext_s == 64'hFFFF_FFFF_FFFF_FFFF);
        spec_res_s = 64'd0;
        if (zero_s) begin
            spec_res_s = ex_op[0] ? a_ext_s : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            spec_res_s = ex_op[0] ? 64'd0 : a_ext_s;
        end
        // Remainder follows the dividend's sign; quotient follows the sign xor
        if (op_q[0]) begin
            fix_neg_s = ~op_q[1] & a_neg_q;
        end else begin
            fix_neg_s = ~op_q[1] & (a_neg_q ^ b_neg_q);
        end
        fix_res_s = word_fix(neg_if(div_result, fix_neg_s), op_q[2]);
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= 3'd0;
            a_neg_q        <= 1'b0;
            b_neg_q        <= 1'b0;
            cnt_q          <= 16'd0;
            ex_ready_q     <= 1'b1;
            wb_valid_q     <= 1'b0;
            err_q          <= 1'b0;
            div_valid_q    <= 1'b0;
            div_mode_q     <= 1'b0;
            wb_data_q      <= 64'd0;
            div_dividend_q <= 64'd0;
            div_divisor_q  <= 64'd0;
        end else begin
            wb_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            div_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid && ex_ready_q) begin
                        op_q       <= ex_op;
                        a_neg_q    <= sgn_s & a_ext_s[63];
                        b_neg_q    <= sgn_s & b_ext_s[63];
                        div_mode_q <= ex_op[0];
                        ex_ready_q <= 1'b0;
                        if (zero_s || ovf_s) begin
                            wb_data_q  <= word_fix(spec_res_s, word_s);
                            wb_valid_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            div_dividend_q <= neg_if(a_ext_s, sgn_s & a_ext_s[63]);
                            div_divisor_q  <= neg_if(b_ext_s, sgn_s & b_ext_s[63]);
                            div_valid_q    <= 1'b1;
                            state_q        <= S_ISSUE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= 16'd0;
                    if (flush) begin
                        state_q <= S_DRAIN;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_out_valid) begin
                        if (flush) begin
                            ex_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            wb_data_q  <= fix_res_s;
                            wb_valid_q <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end else if ((cnt_q + 16'd1) == TMO) begin
                        cnt_q      <= cnt_q + 16'd1;
                        err_q      <= 1'b1;
                        wb_data_q  <= 64'd0;
                        wb_valid_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DONE: begin
                    ex_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                S_DRAIN: begin
                    if (div_out_valid) begin
                        ex_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    ex_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // A flush arriving during the writeback cycle kills the pulse
    assign wb_valid     = wb_valid_q & ~flush;
    assign ex_ready     = ex_ready_q;
    assign wb_data      = wb_data_q;
    assign err          = err_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign div_valid    = div_valid_q;
    assign div_mode     = div_mode_q;
    assign div_signed   = 1'b0;
    assign div_divw     = 1'b0;

endmodule

// File: tb/tb_ysyx_22041412_div_ctrl.sv
// Randomized and directed bench for ysyx_22041412_div_ctrl against an RV64M arithmetic model.
module tb_ysyx_22041412_div_ctrl;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'd0;
    logic [63:0] src1 = 64'd0, src2 = 64'd0;
    logic        flush = 1'b0;
    logic        ex_ready, wb_valid, err, div_valid, div_divw, div_signed, div_mode;
    logic [63:0] wb_data, div_dividend, div_divisor;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_result = 64'd0;

    int checks = 0;
    int errors = 0;

    ysyx_22041412_div_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
        .src1(src1), .src2(src2), .flush(flush), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_data(wb_data), .err(err),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid(div_valid), .div_divw(div_divw), .div_signed(div_signed),
        .div_mode(div_mode), .div_out_valid(div_out_valid), .div_result(div_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV64M result straight from native arithmetic plus the ISA's corner rules
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (op[2]) begin
            a32 = s1[31:0];
            b32 = s2[31:0];
            if (b32 == 32'd0) r32 = op[0] ? a32 : 32'hFFFF_FFFF;
            else if (!op[1] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[0] ? 32'd0 : a32;
            else if (op[1]) r32 = op[0] ? a32 % b32 : a32 / b32;
            else if (op[0]) r32 = $signed(a32) % $signed(b32);
            else r32 = $signed(a32) / $signed(b32);
            return {{32{r32[31]}}, r32};
        end
        if (s2 == 64'd0) r64 = op[0] ? s1 : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!op[1] && s1 == 64'h8000_0000_0000_0000 && s2 == 64'hFFFF_FFFF_FFFF_FFFF) r64 = op[0] ? 64'd0 : s1;
        else if (op[1]) r64 = op[0] ? s1 % s2 : s1 / s2;
        else if (op[0]) r64 = $signed(s1) % $signed(s2);
        else r64 = $signed(s1) / $signed(s2);
        return r64;
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2);
        if (op[2]) return (s2[31:0] == 32'd0) ||
            (!op[1] && s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF);
        return (s2 == 64'd0) ||
            (!op[1] && s1 == 64'h8000_0000_0000_0000 && s2 == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // Magnitude the divider should see for one operand
    function automatic logic [63:0] mag(input logic [2:0] op, input logic [63:0] v);
        longint sv;
        if (op[2]) begin
            if (op[1]) return {32'd0, v[31:0]};
            sv = longint'($signed(v[31:0]));
        end else begin
            if (op[1]) return v;
            sv = longint'(v);
        end
        return (sv < 0) ? 64'(-sv) : 64'(sv);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2);
        chk("ready_before", {63'd0, ex_ready}, 64'd1);
        ex_valid = 1'b1; ex_op = op; src1 = s1; src2 = s2;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2, input int dly);
        logic [63:0] exp;
        exp = ref_res(op, s1, s2);
        accept(op, s1, s2);
        if (is_special(op, s1, s2)) begin
            chk("sp_wbv", {63'd0, wb_valid}, 64'd1);
            chk("sp_data", wb_data, exp);
            chk("sp_divv", {63'd0, div_valid}, 64'd0);
        end else begin
            chk("divv", {63'd0, div_valid}, 64'd1);
            chk("dividend", div_dividend, mag(op, s1));
            chk("divisor", div_divisor, mag(op, s2));
            chk("ctl", {61'd0, div_signed, div_divw, div_mode}, {63'd0, op[0]});
            chk("busy", {63'd0, ex_ready}, 64'd0);
            step();
            chk("divv_off", {63'd0, div_valid}, 64'd0);
            repeat (dly) begin
                chk("no_early_wb", {63'd0, wb_valid}, 64'd0);
                step();
            end
            div_out_valid = 1'b1;
            div_result = div_mode ? (div_dividend % div_divisor) : (div_dividend / div_divisor);
            step();
            div_out_valid = 1'b0;
            chk("wbv", {63'd0, wb_valid}, 64'd1);
            chk("data", wb_data, exp);
            chk("err_quiet", {63'd0, err}, 64'd0);
        end
        step();
        chk("wbv_off", {63'd0, wb_valid}, 64'd0);
        chk("ready_after", {63'd0, ex_ready}, 64'd1);
        chk("data_hold", wb_data, exp);
    endtask

    initial begin
        int seen;
        logic [63:0] seen_data;
        logic seen_err;
        logic [63:0] r1, r2;
        logic [2:0] rop;
        #12;
        chk("rst_ready", {63'd0, ex_ready}, 64'd1);
        chk("rst_outs", {59'd0, wb_valid, err, div_valid, div_mode, div_signed}, 64'd0);
        chk("rst_data", wb_data | div_dividend | div_divisor, 64'd0);
        rst_n = 1'b1;
        step();
        chk("ready_post_rst", {63'd0, ex_ready}, 64'd1);

        do_op(3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2);
        chk("div_neg_val", wb_data, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(3'b101, 64'h0000_0000_FFFF_FFF9, 64'd2, 1);
        do_op(3'b110, 64'h0000_0000_FFFF_FFFE, 64'd1, 0);
        do_op(3'b010, 64'd5, 64'd0, 0);
        do_op(3'b011, 64'd5, 64'd0, 0);
        do_op(3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op(3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op(3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        chk("divw_ovf_val", wb_data, 64'hFFFF_FFFF_8000_0000);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            r1 = {$urandom, $urandom};
            r2 = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: r2 = 64'd0;
                1: r2 = 64'hFFFF_FFFF_FFFF_FFFF;
                2: r2 = 64'($urandom_range(1, 9));
                3: r2 = {$urandom, 32'h0000_0000};
                default: r2 = r2;
            endcase
            case ($urandom_range(0, 7))
                0: r1 = 64'h8000_0000_0000_0000;
                1: r1 = 64'h0000_0000_8000_0000;
                2: r1 = 64'($urandom_range(0, 100));
                default: r1 = r1;
            endcase
            do_op(rop, r1, r2, $urandom_range(0, 4));
        end

        // Flush while idle has no effect
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("idle_flush", {62'd0, ex_ready, wb_valid}, 64'd2);

        // Flush in WAIT, divider answers three cycles later
        accept(3'b000, 64'd100, 64'd7);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("drain_busy", {62'd0, ex_ready, wb_valid}, 64'd0);
            step();
        end
        div_out_valid = 1'b1; div_result = 64'd14;
        step();
        div_out_valid = 1'b0;
        chk("drain_done", {62'd0, ex_ready, wb_valid}, 64'd2);

        // Flush in the same cycle as the divider result
        accept(3'b010, 64'd100, 64'd7);
        step();
        flush = 1'b1; div_out_valid = 1'b1; div_result = 64'd14;
        step();
        flush = 1'b0; div_out_valid = 1'b0;
        chk("flush_resp", {62'd0, ex_ready, wb_valid}, 64'd2);

        // Flush during the writeback cycle
        accept(3'b010, 64'd5, 64'd0);
        flush = 1'b1;
        #1;
        chk("done_flush", {63'd0, wb_valid}, 64'd0);
        step();
        flush = 1'b0;
        chk("done_flush_idle", {62'd0, ex_ready, wb_valid}, 64'd2);

        // Hung divider
        accept(3'b000, 64'd50, 64'd3);
        step();
        seen = 0; seen_err = 1'b0; seen_data = 64'hDEAD;
        for (int k = 1; k <= TMO + 3; k++) begin
            step();
            if (wb_valid && seen == 0) begin
                seen = k; seen_err = err; seen_data = wb_data;
            end
        end
        chk("tmo_cycle", 64'(seen), 64'(TMO));
        chk("tmo_err", {63'd0, seen_err}, 64'd1);
        chk("tmo_data", seen_data, 64'd0);
        chk("tmo_idle", {62'd0, ex_ready, err}, 64'd2);

        // Reset mid-WAIT, then a late divider response must be ignored
        accept(3'b000, 64'd50, 64'd3);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {61'd0, ex_ready, wb_valid, div_valid}, 64'd4);
        step();
        rst_n = 1'b1;
        step();
        div_out_valid = 1'b1; div_result = 64'd16;
        step();
        div_out_valid = 1'b0;
        chk("late_resp", {62'd0, ex_ready, wb_valid}, 64'd2);
        step();
        chk("late_resp2", {63'd0, wb_valid}, 64'd0);
        do_op(3'b000, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22041412_div_ctrl.md
YSYX_22041412_DIV_CTRL -- requirements
Module: ysyx_22041412_div_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 80, max WAIT cycles before the divider is declared hung.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  EXU presents a divide/remainder op.
REQ-005 ex_op  in  3  bit0 = 1 remainder / 0 quotient; bit1 = 1 unsigned; bit2 = 1 word (32-bit) op.
REQ-006 src1, src2  in  64 each  dividend and divisor, raw register values.
REQ-007 flush  in  1  kill the in-flight op.
REQ-008 ex_ready  out  1  block can accept an op.
REQ-009 wb_valid  out  1  one-cycle pulse; wb_data is valid.
REQ-010 wb_data  out  64  final RV64M result.
REQ-011 err  out  1  one-cycle pulse on divider timeout.
REQ-012 div_dividend, div_divisor  out  64 each  unsigned magnitudes sent to the divider.
REQ-013 div_valid, div_divw, div_signed, div_mode  out  1 each  divider controls.
REQ-014 div_out_valid  in  1  divider result valid.
REQ-015 div_result  in  64  divider result.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-017 ex_ready = 1 only in IDLE; an op is accepted when ex_valid & ex_ready, and the operands and ex_op are latched on that edge.
REQ-018 Word ops: operand = src[31:0], sign-extended to 64 if signed, zero-extended if unsigned; zero/overflow checks use these extended values.
REQ-019 Special cases at acceptance (IDLE->DONE, divider never issued):
- divisor == 0: quotient = all ones; remainder = extended dividend.
- Signed overflow (dividend = most-negative for the width, divisor = -1): quotient = dividend; remainder = 0.
REQ-020 Normal ops go IDLE->ISSUE; in ISSUE, div_valid = 1 for exactly one cycle, then WAIT.
REQ-021 Divider drive: div_dividend/div_divisor = absolute values of the extended operands; div_signed = 0; div_divw = 0.
REQ-022 div_mode = latched ex_op[0] and is held stable from ISSUE until the result is captured.
REQ-023 In WAIT, on div_out_valid, capture div_result with sign fixup and go to DONE:
- quotient is negated if the operand signs differ (signed ops only);
- remainder takes the dividend's sign.
REQ-024 In DONE, wb_valid = 1 for one cycle, then IDLE.
REQ-025 wb_data is registered and holds its value until the next DONE.
REQ-026 Word ops: wb_data = sign-extension of result[31:0], including DIVUW/REMUW.
REQ-027 Latency:
- special case: accept at edge T, wb_valid during cycle T+1;
- normal op: div_valid during T+1, wb_valid one cycle after div_out_valid is sampled.
REQ-028 Flush handling:
- flush in ISSUE or WAIT: go to DRAIN, no wb_valid; DRAIN stays until div_out_valid, discards the result, then IDLE.
- flush in DONE: suppress wb_valid, go to IDLE.
- flush in IDLE: no effect.
- div_out_valid and flush in the same WAIT cycle: result discarded, go to IDLE directly.
REQ-029 A 16-bit counter clears on entering WAIT and increments each WAIT cycle.
REQ-030 Timeout: when the counter reaches TIMEOUT_CYCLES, err pulses once, wb_data = 0, and the FSM goes to DONE with wb_valid asserted.
REQ-031 div_out_valid seen in IDLE, ISSUE or DONE is ignored.

Reset
REQ-032 While rst_n = 0 (asserted asynchronously, any state):
- state = IDLE;
- wb_valid, err, div_valid, div_mode, div_signed, div_divw = 0;
- wb_data, div_dividend, div_divisor, counter = 0;
- ex_ready = 1 on the first cycle after release.
REQ-033 An op in flight at reset is abandoned with no wb_valid; any late div_out_valid is ignored per REQ-031.

Verification
REQ-034 DIV: src1 = 0xFFFFFFFFFFFFFFF9, src2 = 2 -> divider sees 7, 2, div_signed = 0; wb_data = 0xFFFFFFFFFFFFFFFD.
REQ-035 REMW: src1 = 0x00000000FFFFFFF9, src2 = 0x2 -> wb_data = 0xFFFFFFFFFFFFFFFF; DIVUW: src1 = 0xFFFFFFFE, src2 = 1 -> wb_data = 0xFFFFFFFFFFFFFFFE.
REQ-036 Divide by zero: DIVU 5/0 -> wb_data = 0xFFFFFFFFFFFFFFFF at T+1; REMU 5/0 -> 5; div_valid never asserted.
REQ-037 Overflow: DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000; REM -> 0; DIVW 0x80000000 / 0xFFFFFFFF -> 0xFFFFFFFF80000000.
REQ-038 Flush in WAIT, divider responds 3 cycles later -> no wb_valid; ex_ready = 1 only after that response.
REQ-039 Divider stub never responds -> err pulse and wb_valid with wb_data = 0 exactly TIMEOUT_CYCLES cycles after entering WAIT; rst_n low mid-WAIT -> IDLE immediately.
